// File: rtl/four_serial_sub.sv
// Bit-serial 4-bit subtractor D = A - B, LSB first, one bit per clock.
// Operands are captured on START; D/BOUT/V update only when the last bit completes.
module four_serial_sub (
  input  logic CLK,
  input  logic RST_N,
  input  logic START,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic BOUT,
  output logic V,
  output logic BUSY,
  output logic DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        br_q;
  logic [3:0]  a_q;
  logic [3:0]  b_q;
  logic [2:0]  res_q;
  logic [3:0]  d_q;
  logic        bout_q;
  logic        v_q;
  logic        busy_q;
  logic        done_q;

  logic        aBit;
  logic        bBit;
  logic        dBit_d;
  logic        br_d;

  // The current bit always sits at position 0 of the operand shift registers.
  always_comb begin
    aBit   = a_q[0];
    bBit   = b_q[0];
    dBit_d = aBit ^ bBit ^ br_q;
    br_d   = (~aBit & bBit) | (~(aBit ^ bBit) & br_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      br_q    <= 1'b0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      res_q   <= 3'd0;
      d_q     <= 4'd0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (START) begin
            a_q     <= {A3, A2, A1, A0};
            b_q     <= {B3, B2, B1, B0};
            br_q    <= 1'b0;
            cnt_q   <= 2'd0;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= {dBit_d, res_q[2:1]};
          cnt_q <= cnt_q + 2'd1;
          // On the last bit the operand LSBs are the original sign bits.
          if (cnt_q == 2'd3) begin
            d_q     <= {dBit_d, res_q};
            bout_q  <= br_d;
            v_q     <= (aBit != bBit) & (dBit_d != aBit);
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign D0   = d_q[0];
  assign D1   = d_q[1];
  assign D2   = d_q[2];
  assign D3   = d_q[3];
  assign BOUT = bout_q;
  assign V    = v_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_four_serial_sub.sv
// Self-checking bench for four_serial_sub: arithmetic/timing model plus directed vectors.
module tb_four_serial_sub;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic [3:0] aVec = 4'd0;
  logic [3:0] bVec = 4'd0;
  logic       D0, D1, D2, D3, BOUT, V, BUSY, DONE;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  four_serial_sub dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .A0   (aVec[0]),
    .A1   (aVec[1]),
    .A2   (aVec[2]),
    .A3   (aVec[3]),
    .B0   (bVec[0]),
    .B1   (bVec[1]),
    .B2   (bVec[2]),
    .B3   (bVec[3]),
    .D0   (D0),
    .D1   (D1),
    .D2   (D2),
    .D3   (D3),
    .BOUT (BOUT),
    .V    (V),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  // Model: phase 0 idle, 1..4 busy cycles, 5 the done cycle; result from plain arithmetic.
  int phase = 0;
  int pendA = 0;
  int pendB = 0;
  logic [3:0] expD = 4'd0;
  logic expBout = 1'b0;
  logic expV = 1'b0;

  always @(posedge CLK) begin
    int sa;
    int sb;
    int diff;
    if (!RST_N) begin
      phase = 0;
      expD = 4'd0;
      expBout = 1'b0;
      expV = 1'b0;
    end else if ((phase == 0 || phase == 5) && START) begin
      phase = 1;
      pendA = int'(aVec);
      pendB = int'(bVec);
    end else if (phase >= 1 && phase <= 3) begin
      phase = phase + 1;
    end else if (phase == 4) begin
      phase = 5;
      expD = 4'((pendA - pendB + 16) % 16);
      expBout = (pendA < pendB);
      sa = (pendA >= 8) ? pendA - 16 : pendA;
      sb = (pendB >= 8) ? pendB - 16 : pendB;
      diff = sa - sb;
      expV = (diff > 7) || (diff < -8);
    end else begin
      phase = 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    logic [7:0] act;
    logic [7:0] exp;
    if (checkEn) begin
      act = {D3, D2, D1, D0, BOUT, V, BUSY, DONE};
      exp = {expD, expBout, expV, (phase >= 1 && phase <= 4), (phase == 5)};
      checkOutput("model {D,BOUT,V,BUSY,DONE}", int'(act), int'(exp));
      checkOutput("busy&done exclusive", int'(BUSY & DONE), 0);
    end
  end

  task automatic applyStimulus(input int a, input int b);
    aVec = 4'(a);
    bVec = 4'(b);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    aVec = 4'(15 - a);
    bVec = 4'(b ^ 5);
  endtask

  // Returns number of negedges since the START cycle (1 already elapsed), or -1 on timeout.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge CLK);
      if (DONE) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic checkResult(input string name, input int d, input int bo, input int v);
    checkOutput({name, " D"}, int'({D3, D2, D1, D0}), d);
    checkOutput({name, " BOUT"}, int'(BOUT), bo);
    checkOutput({name, " V"}, int'(V), v);
  endtask

  initial begin
    int lat;
    int pulses;

    RST_N = 1'b0;
    @(negedge CLK);
    checkEn = 1'b1;
    @(negedge CLK);
    checkResult("reset", 0, 0, 0);
    checkOutput("reset BUSY", int'(BUSY), 0);
    checkOutput("reset DONE", int'(DONE), 0);
    RST_N = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) pulses++;
    end
    checkOutput("idle activity", pulses, 0);

    applyStimulus(15, 9);
    waitDone(lat);
    checkOutput("15-9 latency", lat, 5);
    checkResult("15-9", 6, 0, 0);

    applyStimulus(5, 10);
    waitDone(lat);
    checkOutput("5-10 latency", lat, 5);
    checkResult("5-10", 11, 1, 1);

    applyStimulus(8, 12);
    waitDone(lat);
    checkOutput("8-12 latency", lat, 5);
    checkResult("8-12", 12, 1, 0);
    aVec = 4'd1;
    bVec = 4'd14;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checkOutput("b2b held result D", int'({D3, D2, D1, D0}), 12);
    waitDone(lat);
    checkOutput("1-14 b2b latency", lat, 5);
    checkResult("1-14", 3, 1, 0);

    applyStimulus(15, 9);
    aVec = 4'd0;
    bVec = 4'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
    checkOutput("ignored START pulses", pulses, 1);
    checkResult("ignored START", 6, 0, 0);

    applyStimulus(0, 1);
    waitDone(lat);
    checkOutput("0-1 latency", lat, 5);
    checkResult("0-1", 15, 1, 0);

    applyStimulus(5, 10);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checkResult("mid reset", 0, 0, 0);
    checkOutput("mid reset BUSY", int'(BUSY), 0);
    checkOutput("mid reset DONE", int'(DONE), 0);
    RST_N = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
    checkOutput("aborted op pulses", pulses, 0);

    applyStimulus(5, 10);
    waitDone(lat);
    checkOutput("after reset latency", lat, 5);
    checkResult("after reset 5-10", 11, 1, 1);

    @(negedge CLK);
    @(negedge CLK);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
